// File: rtl/serial_subtractor.sv
// Multi-cycle unsigned subtractor: d = x - y - b_in, k bits per clock, LSB digit first,
// with a registered borrow between digits and a start/busy/done handshake.
module serial_subtractor #(
  parameter int n = 16,
  parameter int k = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [n-1:0] x,
  input  logic [n-1:0] y,
  input  logic         b_in,
  output logic         busy,
  output logic         done,
  output logic [n-1:0] d,
  output logic         b_out
);

  localparam int DIGITS = n / k;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST_DIGIT = CW'(DIGITS - 1);

  generate
    if ((n % k) != 0) begin : g_bad_cfg
      $error("serial_subtractor: n must be a multiple of k");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t        state_r;
  logic [CW-1:0] cnt_r;
  logic [n-1:0]  x_r;
  logic [n-1:0]  y_r;
  logic [n-1:0]  d_r;
  logic          bor_r;
  logic          busy_r;
  logic          done_r;
  logic          b_out_r;

  logic [k:0]    dig_s;
  logic [n-1:0]  dig_ext_s;
  logic [n-1:0]  d_next_s;

  // Operands shift right each RUN cycle, so the active digit is always the low k bits;
  // the result digit enters at the top of d and reaches its final place after n/k steps.
  assign dig_s     = {1'b0, x_r[k-1:0]} - {1'b0, y_r[k-1:0]} - {{k{1'b0}}, bor_r};
  assign dig_ext_s = n'(dig_s[k-1:0]);
  assign d_next_s  = (d_r >> k) | (dig_ext_s << (n - k));

  // Handshake FSM, digit counter and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      x_r     <= '0;
      y_r     <= '0;
      d_r     <= '0;
      bor_r   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      b_out_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE, FIN: begin
          done_r <= 1'b0;
          if (start) begin
            x_r     <= x;
            y_r     <= y;
            bor_r   <= b_in;
            cnt_r   <= '0;
            busy_r  <= 1'b1;
            state_r <= RUN;
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        RUN: begin
          x_r   <= x_r >> k;
          y_r   <= y_r >> k;
          bor_r <= dig_s[k];
          d_r   <= d_next_s;
          cnt_r <= cnt_r + CW'(1);
          if (cnt_r == LAST_DIGIT) begin
            b_out_r <= dig_s[k];
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= FIN;
          end else begin
            state_r <= RUN;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign busy  = busy_r;
  assign done  = done_r;
  assign d     = d_r;
  assign b_out = b_out_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: a 16/4 and a 34/2 instance checked against
// integer arithmetic, with handshake timing derived from the accept/latency rules.
module tb_serial_subtractor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start0, start1, b_in0, b_in1;
  logic        busy0, busy1, done0, done1, b_out0, b_out1;
  logic [15:0] x16, y16, d16;
  logic [33:0] x34, y34, d34;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int          unit;
    logic [33:0] d;
    logic        b;
  } exp_t;

  exp_t        exp_q[$];
  int          acc_edge[2];
  int          free_at[2];
  logic [33:0] last_d[2];
  logic        last_b[2];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  serial_subtractor #(.n(16), .k(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start0), .x(x16), .y(y16), .b_in(b_in0),
    .busy(busy0), .done(done0), .d(d16), .b_out(b_out0)
  );

  serial_subtractor #(.n(34), .k(2)) dut34 (
    .clk(clk), .rst_n(rst_n), .start(start1), .x(x34), .y(y34), .b_in(b_in1),
    .busy(busy1), .done(done1), .d(d34), .b_out(b_out1)
  );

  function automatic int digits(input int u);
    return (u == 0) ? 4 : 17;
  endfunction

  task automatic chk(input string nm, input int u, input logic [34:0] act, input logic [34:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s unit%0d cycle %0d: got %h required %h", nm, u, cyc, act, req);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    for (int u = 0; u < 2; u++) begin
      acc_edge[u] = -100;
      free_at[u]  = 0;
      last_d[u]   = '0;
      last_b[u]   = 1'b0;
    end
  endtask

  // Drive one cycle of inputs for unit u; at the following edge decide acceptance and
  // push the expected result computed with plain integer arithmetic.
  task automatic drive_cycle(input int u, input logic s, input logic [33:0] xv,
                             input logic [33:0] yv, input logic bv, output logic acc);
    logic [33:0] xm, ym;
    longint      diff;
    int          w;
    exp_t        e;
    #1;
    if (u == 0) begin
      start0 = s; x16 = xv[15:0]; y16 = yv[15:0]; b_in0 = bv;
    end else begin
      start1 = s; x34 = xv; y34 = yv; b_in1 = bv;
    end
    @(posedge clk);
    acc = s && rst_n && (cyc >= free_at[u]);
    if (acc) begin
      w  = (u == 0) ? 16 : 34;
      xm = (u == 0) ? {18'd0, xv[15:0]} : xv;
      ym = (u == 0) ? {18'd0, yv[15:0]} : yv;
      diff   = longint'(xm) - longint'(ym) - longint'(bv);
      e.unit = u;
      e.b    = (diff < 0);
      e.d    = 34'(diff + (e.b ? (longint'(1) << w) : longint'(0)));
      exp_q.push_back(e);
      acc_edge[u] = cyc;
      free_at[u]  = cyc + digits(u) + 1;
    end
  endtask

  task automatic op(input int u, input logic [33:0] xv, input logic [33:0] yv, input logic bv);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) drive_cycle(u, 1'b1, xv, yv, bv, acc);
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL accept_timeout unit%0d: got no accept required accept within 50 cycles", u);
    end
  endtask

  task automatic idle(input int u, input int n_cyc);
    logic acc;
    for (int i = 0; i < n_cyc; i++)
      drive_cycle(u, 1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), acc);
  endtask

  function automatic logic [33:0] rnd34();
    logic [33:0] v;
    case ($urandom_range(0, 5))
      0:       v = '0;
      1:       v = '1;
      default: v = {2'($urandom), 32'($urandom)};
    endcase
    return v;
  endfunction

  // Monitor: compares busy/done against the accept timeline every cycle, pops the
  // scoreboard on done and checks that results hold while idle.
  initial begin
    int          e, dn;
    int          idx;
    logic        bexp, dexp;
    logic        act_busy, act_done, act_b;
    logic [33:0] act_d;
    forever begin
      @(negedge clk);
      e = cyc - 1;
      for (int u = 0; u < 2; u++) begin
        dn       = digits(u);
        bexp     = (e >= acc_edge[u]) && (e < acc_edge[u] + dn);
        dexp     = (e == acc_edge[u] + dn);
        act_busy = (u == 0) ? busy0 : busy1;
        act_done = (u == 0) ? done0 : done1;
        act_b    = (u == 0) ? b_out0 : b_out1;
        act_d    = (u == 0) ? {18'd0, d16} : d34;
        chk("busy", u, 35'(act_busy), 35'(bexp));
        chk("done", u, 35'(act_done), 35'(dexp));
        if (dexp) begin
          idx = -1;
          for (int i = 0; i < exp_q.size() && idx < 0; i++)
            if (exp_q[i].unit == u) idx = i;
          checks++;
          if (idx < 0) begin
            errors++;
            $display("FAIL scoreboard_empty unit%0d: got done required a queued result", u);
          end else begin
            last_d[u] = exp_q[idx].d;
            last_b[u] = exp_q[idx].b;
            exp_q.delete(idx);
          end
          chk("result", u, {act_b, act_d}, {last_b[u], last_d[u]});
        end else if (!bexp) begin
          chk("hold", u, {act_b, act_d}, {last_b[u], last_d[u]});
        end
      end
    end
  end

  initial begin
    logic acc;
    start0 = 1'b0; start1 = 1'b0; b_in0 = 1'b0; b_in1 = 1'b0;
    x16 = '0; y16 = '0; x34 = '0; y34 = '0;
    model_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // 16-bit unit: directed corners, then start held high with fresh operands every cycle.
    op(0, 34'h1234, 34'h0234, 1'b0);
    idle(0, 6);
    op(0, 34'h0000, 34'h0001, 1'b0);
    op(0, 34'h8000, 34'h7FFF, 1'b1);
    idle(0, 3);
    for (int i = 0; i < 15; i++)
      drive_cycle(0, 1'b1, rnd34(), rnd34(), 1'($urandom), acc);
    idle(0, 6);
    for (int i = 0; i < 500; i++) begin
      op(0, rnd34(), rnd34(), 1'($urandom));
      idle(0, $urandom_range(0, 2));
    end
    idle(0, 6);

    // 34-bit unit.
    op(1, 34'h3_FFFF_FFFF, 34'h0_0000_0001, 1'b0);
    op(1, 34'h0, 34'h3_FFFF_FFFF, 1'b1);
    for (int i = 0; i < 500; i++) begin
      op(1, rnd34(), rnd34(), 1'($urandom));
      idle(1, $urandom_range(0, 2));
    end
    idle(1, 20);

    // Reset in the second RUN cycle discards the operation; a fresh start then completes.
    op(0, 34'hFFFF, 34'h0001, 1'b0);
    idle(0, 1);
    #1 rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    op(0, 34'hFFFF, 34'h0001, 1'b0);
    idle(0, 25);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_results: got %0d pending required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
